// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and defaults for the debounce_sync block.
// Provides the FSM state type, default parameters and a state helper.
package debounce_pkg;

    // Default synchroniser depth and stability window
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHK_HI    = 2'b01,
        STABLE_HI = 2'b10,
        CHK_LO    = 2'b11
    } state_t;

    // True while a candidate transition is being counted
    function automatic logic is_checking(input state_t st);
        return (st == CHK_HI) || (st == CHK_LO);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: plain flop shift chain for bringing an async bit into clk.
// Ports: clk, async_reset_n (async active-low), d (async in), q (synced out).
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic async_reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronise a raw input, reject bounces, emit edge pulses.
// Ports: clk, async_reset_n, din, enable -> dout, rise_pulse, fall_pulse, busy.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic async_reset_n,
    input  logic din,
    input  logic enable,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    // Elaboration-time parameter sanity checks
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_sync: STABLE_CYCLES must be >= 1");
    end
    if ((2 ** CNT_W) <= STABLE_CYCLES) begin : g_bad_cnt
        $error("debounce_sync: CNT_W too narrow for STABLE_CYCLES");
    end

    // Transition completes when cnt reaches the last count value
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               ONE_SHOT = (STABLE_CYCLES == 1);

    logic             s;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             dout_n;
    logic             rise_n;
    logic             fall_n;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .d             (din),
        .q             (s)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dout_n  = dout;
        rise_n  = 1'b0;
        fall_n  = 1'b0;

        if (enable) begin
            unique case (state)
                STABLE_LO: begin
                    if (s) begin
                        if (ONE_SHOT) begin
                            state_n = STABLE_HI;
                            dout_n  = 1'b1;
                            rise_n  = 1'b1;
                        end else begin
                            state_n = CHK_HI;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end

                CHK_HI: begin
                    if (!s) begin
                        // glitch rejected, output untouched
                        state_n = STABLE_LO;
                        cnt_n   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_n = STABLE_HI;
                        cnt_n   = '0;
                        dout_n  = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end

                STABLE_HI: begin
                    if (!s) begin
                        if (ONE_SHOT) begin
                            state_n = STABLE_LO;
                            dout_n  = 1'b0;
                            fall_n  = 1'b1;
                        end else begin
                            state_n = CHK_LO;
                            cnt_n   = CNT_ONE;
                        end
                    end
                end

                CHK_LO: begin
                    if (s) begin
                        state_n = STABLE_HI;
                        cnt_n   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_n = STABLE_LO;
                        cnt_n   = '0;
                        dout_n  = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // busy is registered alongside state so it lines up with dout
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            dout       <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dout       <= dout_n;
            rise_pulse <= rise_n;
            fall_pulse <= fall_n;
            busy       <= is_checking(state_n);
        end
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input (push-button, external strobe) into a clean, clock-aligned level for the downstream D flip-flop's D input.
- Synchronises the input, then rejects bounces with a stability counter.
- Also emits single-cycle rise and fall pulses for control logic that needs edges rather than levels.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on din; legal values >= 2.
- STABLE_CYCLES, 4, consecutive cycles the synchronised value must differ from dout before dout flips; legal values >= 1.
- CNT_W, 8, counter width; requires 2**CNT_W > STABLE_CYCLES, with an elaboration-time check.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- async_reset_n  input  1  asynchronous, active-low reset; all flops clear immediately on assertion.
- din  input  1  raw asynchronous input; no timing relation to clk.
- enable  input  1  high = debounce runs; low = FSM and counter frozen.
- dout  output  1  debounced level; drives the downstream d_ff D.
- rise_pulse  output  1  one-cycle high when dout goes 0->1.
- fall_pulse  output  1  one-cycle high when dout goes 1->0.
- busy  output  1  high while a candidate transition is being counted.

Behaviour:
- Reset (async_reset_n=0):
  - sync chain, dout, rise_pulse, fall_pulse, busy and cnt all go to 0 at once, with no clock edge needed.
  - State goes to STABLE_LO.
  - Deassertion is synchronised externally.
- Synchroniser:
  - s = output of the SYNC_STAGES-deep flop chain.
  - The chain always shifts, even when enable=0.
- FSM states and transitions:
  - STABLE_LO: dout=0, cnt=0. If s=1, go to CHK_HI with cnt=1, or flip directly when STABLE_CYCLES=1.
  - CHK_HI:
    - s=1 and cnt==STABLE_CYCLES-1: go to STABLE_HI, set dout=1, pulse rise_pulse, clear cnt.
    - s=1 otherwise: increment cnt.
    - s=0: return to STABLE_LO and clear cnt, with no output change (glitch rejected).
  - STABLE_HI and CHK_LO mirror STABLE_LO and CHK_HI with polarity inverted; the completed transition sets dout=0 and pulses fall_pulse.
- Latency: a din change held steady and captured at edge 1 updates dout at edge SYNC_STAGES+STABLE_CYCLES. With defaults this is edge 6.
- Pulse timing:
  - rise_pulse/fall_pulse are registered and assert on the same edge that updates dout.
  - They are high for exactly one cycle and never both high.
- busy = 1 exactly while in CHK_HI or CHK_LO; it is registered with the state.
- enable=0:
  - State, cnt and dout hold; pulses are forced to 0.
  - On re-enable, counting resumes from the held cnt, compared against the current s.
- Edge cases:
  - Glitch shorter than STABLE_CYCLES (after sync): no dout change, no pulse.
  - A reversal on the final count cycle also aborts the transition.
  - Counter saturation cannot occur because the transition completes at STABLE_CYCLES-1; the CNT_W check guarantees headroom.
- Reset mid-count: the transition is aborted and all outputs drop to 0 asynchronously. After release with din=1, a full-latency rise follows and rise_pulse fires.
- Reset exit: a din already high at release is treated as a fresh 0->1 transition.

Decomposition:
- debounce_pkg:
  - state typedef {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} with 2-bit encoding.
  - Default constants for SYNC_STAGES and STABLE_CYCLES.
- Sub-module sync_chain (parameter STAGES; ports clk, async_reset_n, d, q): plain flop shift chain reset to 0. It is reused by other CDC inputs in the codebase.

Test Plan (defaults, clk period 20 ns):
- Reset hold: async_reset_n=0, din=1, 10 cycles -> dout=0, rise_pulse=0, fall_pulse=0, busy=0 throughout; asserting reset between edges clears outputs in the same timestep.
- Clean rise: release reset, enable=1, din 0->1 before edge 1 and held -> busy=1 after edges 3-5, dout=1 after edge 6, rise_pulse=1 for the edge 6-7 cycle only.
- Bounce rejection: din=1 for 3 cycles then 0, repeated 4 times -> dout stays 0, no pulses, busy toggles and ends at 0.
- Clean fall: from dout=1, din 1->0 held -> dout=0 and fall_pulse=1 one cycle at edge 6; rise_pulse stays 0.
- Reset mid-count: din rises, assert reset after edge 4 (busy=1) -> dout/busy/cnt clear at once; release with din=1 -> dout=1 and rise_pulse exactly 6 edges after release.
- Enable freeze: din rises, drop enable after edge 4 for 5 cycles -> busy holds 1, dout 0, no pulse; re-enable -> dout=1 after 2 more edges (cnt resumes from 2), rise_pulse fires once.
